// File: rtl/lc3b_types.sv
// Shared LC-3b data types used by the cache hierarchy and its memory model.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_8words;
    typedef logic [11:0]  lc3b_line_adr;
    typedef logic [15:0]  lc3b_line_sel;

    localparam int unsigned MEM_LATENCY_DEFAULT = 32'd10;

endpackage

// File: rtl/wb_line_ram.sv
// Line-wide storage array: byte-enabled write port and a registered read port.
module wb_line_ram
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  lc3b_line_sel      wr_be,
    input  lc3b_8words        wr_data,
    output lc3b_8words        rd_data
);

    lc3b_8words mem_r [0:(1<<ADDR_W)-1];
    lc3b_8words rd_data_r;

    // Byte-granular line write; contents are deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 16; i++) begin
                if (wr_be[i]) begin
                    mem_r[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register holds the last line read until the next read completes
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= 128'd0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/wb_line_memory.sv
// Wishbone slave modelling main memory: fixed-latency 128-bit line reads and
// byte-enabled line writes, with RTY while pending and a one-cycle ACK.
module wb_line_memory
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CYC,
    input  logic              STB,
    input  logic              WE,
    input  logic [15:0]       SEL,
    input  logic [ADDR_W-1:0] ADR,
    input  lc3b_8words        DAT_M,
    output lc3b_8words        DAT_S,
    output logic              ACK,
    output logic              RTY,
    output lc3b_word          read_count,
    output lc3b_word          write_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 32'd1);

    logic [1:0]        state_r, state_next_s;
    logic [7:0]        count_r, count_next_s;
    logic              ack_r;
    logic [ADDR_W-1:0] adr_r;
    logic              we_r;
    lc3b_line_sel      sel_r;
    lc3b_8words        dat_r;
    lc3b_word          read_count_r, write_count_r;
    logic              req_s, capture_s, fire_s;
    logic              ram_wr_s, ram_rd_s;

    assign req_s     = CYC & STB;
    assign capture_s = (state_r == ST_IDLE) & req_s;
    // The access fires on the edge where the countdown would reach zero
    assign fire_s    = (state_r == ST_BUSY) & req_s & (count_r == 8'd1);

    // Next-state and countdown logic; a dropped strobe while busy aborts
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_next_s = ST_BUSY;
                    count_next_s = LAT_M1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!req_s) begin
                    state_next_s = ST_IDLE;
                end else if (count_r == 8'd1) begin
                    state_next_s = ST_RESP;
                    count_next_s = 8'd0;
                end else begin
                    count_next_s = count_r - 8'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = 8'd0;
            end
        endcase
    end

    // State, countdown and ACK registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= 8'd0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            ack_r   <= fire_s;
        end
    end

    // Request capture; later bus changes during the wait are ignored
    always_ff @(posedge clk) begin
        if (capture_s) begin
            adr_r <= ADR;
            we_r  <= WE;
            sel_r <= SEL;
            dat_r <= DAT_M;
        end
    end

    // Performance counters, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count_r  <= 16'd0;
            write_count_r <= 16'd0;
        end else if (fire_s && we_r) begin
            write_count_r <= write_count_r + 16'd1;
        end else if (fire_s) begin
            read_count_r  <= read_count_r + 16'd1;
        end
    end

    assign ram_wr_s = fire_s & we_r & ~reset;
    assign ram_rd_s = fire_s & ~we_r & ~reset;

    wb_line_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_wr_s),
        .rd_en   (ram_rd_s),
        .addr    (adr_r),
        .wr_be   (sel_r),
        .wr_data (dat_r),
        .rd_data (DAT_S)
    );

    assign ACK         = ack_r;
    assign RTY         = req_s & ~ack_r;
    assign read_count  = read_count_r;
    assign write_count = write_count_r;

endmodule

// File: tb/tb_wb_line_memory.sv
// Scoreboard bench for wb_line_memory: two instances (latency 10 and 2),
// directed cases plus randomized traffic against a line-level memory model.
module tb_wb_line_memory;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, CYC, STB, CYC2, STB2, WE;
    logic [15:0]  SEL;
    logic [11:0]  ADR;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S, DAT_S2;
    logic         ACK, RTY, ACK2, RTY2;
    logic [15:0]  read_count, write_count, read_count2, write_count2;

    wb_line_memory #(.LATENCY(10), .ADDR_W(12)) u_dut (
        .clk(clk), .reset(reset), .CYC(CYC), .STB(STB), .WE(WE), .SEL(SEL),
        .ADR(ADR), .DAT_M(DAT_M), .DAT_S(DAT_S), .ACK(ACK), .RTY(RTY),
        .read_count(read_count), .write_count(write_count));

    wb_line_memory #(.LATENCY(2), .ADDR_W(12)) u_dut2 (
        .clk(clk), .reset(reset), .CYC(CYC2), .STB(STB2), .WE(WE), .SEL(SEL),
        .ADR(ADR), .DAT_M(DAT_M), .DAT_S(DAT_S2), .ACK(ACK2), .RTY(RTY2),
        .read_count(read_count2), .write_count(write_count2));

    typedef struct {
        int           ack_cyc;
        logic [127:0] dat;
        logic [15:0]  rc;
        logic [15:0]  wc;
    } exp_t;

    exp_t         q0[$], q1[$];
    logic [127:0] mem_m [int];
    logic [15:0]  rc_m [2];
    logic [15:0]  wc_m [2];
    logic [127:0] last_m [2];
    int           n_cmp = 0, n_fail = 0, cyc = 0;
    int           lat_of [2] = '{10, 2};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic ack, input logic rty, input logic [127:0] dat,
                       input logic [15:0] rc, input logic [15:0] wc);
        exp_t e;
        int   qs;
        if (ack || rty) chk("ack_rty_exclusive", 128'(ack & rty), 128'd0);
        if (ack) begin
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: dut%0d got ACK=1 expected no ACK (cycle %0d)", d, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("ack_latency", 128'(cyc), 128'(e.ack_cyc));
                chk("dat_s", dat, e.dat);
                chk("read_count", 128'(rc), 128'(e.rc));
                chk("write_count", 128'(wc), 128'(e.wc));
            end
        end
    endtask

    // Monitor: every output cycle is checked against queued expectations
    always @(negedge clk) begin
        mon(0, ACK, RTY, DAT_S, read_count, write_count);
        mon(1, ACK2, RTY2, DAT_S2, read_count2, write_count2);
    end

    task automatic set_stb(input int d, input logic v);
        if (d == 0) begin CYC = v; STB = v; end
        else        begin CYC2 = v; STB2 = v; end
    endtask

    // Reference model: apply the access as a whole line and queue the response
    task automatic model_push(input int d, input logic we, input logic [11:0] adr,
                              input logic [15:0] sel, input logic [127:0] dat);
        exp_t         e;
        logic [127:0] line;
        int           k;
        k = d * 4096 + int'(adr);
        line = mem_m.exists(k) ? mem_m[k] : 128'd0;
        if (we) begin
            for (int i = 0; i < 16; i++)
                if (sel[i]) line[8*i +: 8] = dat[8*i +: 8];
            mem_m[k] = line;
            wc_m[d] = wc_m[d] + 16'd1;
        end else begin
            last_m[d] = line;
            rc_m[d] = rc_m[d] + 16'd1;
        end
        e.ack_cyc = cyc + lat_of[d];
        e.dat = last_m[d];
        e.rc = rc_m[d];
        e.wc = wc_m[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ack(input int d);
        bit got = 1'b0;
        int lat = lat_of[d];
        for (int n = 1; n <= lat + 3 && !got; n++) begin
            @(negedge clk);
            if ((d == 0) ? ACK : ACK2) got = 1'b1;
            else begin
                chk("rty_pending", 128'((d == 0) ? RTY : RTY2), 128'd1);
                ADR = 12'($urandom);
                DAT_M = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout: dut%0d got no ACK expected ACK within %0d cycles", d, lat + 3);
        end
        set_stb(d, 1'b0);
    endtask

    task automatic drive(input int d, input logic we, input logic [11:0] adr,
                         input logic [15:0] sel, input logic [127:0] dat);
        @(negedge clk);
        WE = we; ADR = adr; SEL = sel; DAT_M = dat;
        set_stb(d, 1'b1);
    endtask

    task automatic req(input int d, input logic we, input logic [11:0] adr,
                       input logic [15:0] sel, input logic [127:0] dat);
        drive(d, we, adr, sel, dat);
        model_push(d, we, adr, sel, dat);
        wait_ack(d);
    endtask

    logic [11:0] pool [8];

    initial begin
        reset = 1'b1; CYC = 1'b0; STB = 1'b0; CYC2 = 1'b0; STB2 = 1'b0;
        WE = 1'b0; SEL = 16'd0; ADR = 12'd0; DAT_M = 128'd0;
        for (int d = 0; d < 2; d++) begin rc_m[d] = 16'd0; wc_m[d] = 16'd0; last_m[d] = 128'd0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ack", 128'(ACK), 128'd0);
        chk("reset_rty", 128'(RTY), 128'd0);
        chk("reset_dat_s", DAT_S, 128'd0);
        chk("reset_read_count", 128'(read_count), 128'd0);
        chk("reset_write_count", 128'(write_count), 128'd0);
        chk("reset_ack_lat2", 128'(ACK2), 128'd0);

        // Full write then read-back
        req(0, 1'b1, 12'h123, 16'hFFFF, 128'h00112233445566778899AABBCCDDEEFF);
        req(0, 1'b0, 12'h123, 16'h0000, 128'd0);
        // Partial write: low four bytes only
        req(0, 1'b1, 12'h123, 16'h000F, {16{8'hAA}});
        req(0, 1'b0, 12'h123, 16'h0000, 128'd0);

        // Aborted write leaves memory and counters alone
        req(0, 1'b1, 12'h050, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
        drive(0, 1'b1, 12'h050, 16'hFFFF, {4{32'hDEADBEEF}});
        repeat (4) @(negedge clk);
        set_stb(0, 1'b0);
        repeat (14) @(negedge clk);
        req(0, 1'b0, 12'h050, 16'h0000, 128'd0);

        // Reset while a read is busy; strobe stays high so a fresh request follows
        drive(0, 1'b0, 12'h123, 16'h0000, 128'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ADR = 12'h123; WE = 1'b0;
        chk("midreset_ack", 128'(ACK), 128'd0);
        chk("midreset_dat_s", DAT_S, 128'd0);
        chk("midreset_read_count", 128'(read_count), 128'd0);
        chk("midreset_write_count", 128'(write_count), 128'd0);
        for (int d = 0; d < 2; d++) begin rc_m[d] = 16'd0; wc_m[d] = 16'd0; last_m[d] = 128'd0; end
        model_push(0, 1'b0, 12'h123, 16'h0000, 128'd0);
        wait_ack(0);

        // Randomized traffic over a prewritten pool of lines on both instances
        for (int i = 0; i < 8; i++) pool[i] = 12'h200 + 12'(i * 17);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                req(d, 1'b1, pool[i], 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 30; i++)
            req(int'($urandom_range(1, 0)), 1'($urandom), pool[$urandom_range(7, 0)],
                16'($urandom), {$urandom, $urandom, $urandom, $urandom});

        // Counter wrap on the short-latency instance
        @(negedge clk);
        force u_dut2.write_count_r = 16'hFFFF;
        @(negedge clk);
        release u_dut2.write_count_r;
        wc_m[1] = 16'hFFFF;
        req(1, 1'b1, pool[0], 16'h00FF, {4{32'h5A5A5A5A}});
        req(1, 1'b0, pool[0], 16'h0000, 128'd0);

        repeat (4) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pending_responses: got %0d/%0d outstanding expected 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
